// File: rtl/chrono_controller_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encodings and
// default timing constants for the quartz-derived prescaler and button debouncers.
package chrono_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_LAP     = 3'd2,
    ST_STOPPED = 3'd3,
    ST_CLEAR   = 3'd4
  } state_e;

  localparam int unsigned DEF_PRESCALE = 500000;
  localparam int unsigned DEF_DEBOUNCE = 1000000;

endpackage

// File: rtl/chrono_controller_button_debounce.sv
// Two-flop synchronizer plus debouncer for one push-button; emits a single-cycle
// press pulse once a high level has been stable for DEBOUNCE cycles.
module button_debounce
  import chrono_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic qzt_clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [1:0]    prime_q, prime_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // The accepted level starts high after reset, so a button must be seen low
  // for DEBOUNCE cycles before a press counts. The prime shift keeps the reset
  // values of the synchronizer from being counted as genuine low samples.
  always_comb begin
    sync1_d     = btn;
    sync2_d     = sync1_q;
    prime_d     = {prime_q[0], 1'b1};
    level_d     = level_q;
    level_dly_d = level_q;
    cnt_d       = '0;
    if (prime_q[1] && (sync2_q != level_q)) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prime_q     <= '0;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prime_q     <= prime_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/chrono_controller.sv
// Stopwatch control: debounced start/stop and lap/reset buttons drive an FSM
// that gates a prescaled count clock, the counter clear pulse and the lap freeze.
module chrono_controller
  import chrono_controller_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       count_clk,
  output logic       counter_clr,
  output logic       freeze,
  output logic       running,
  output logic [2:0] state
);

  localparam int unsigned PW   = $clog2(PRESCALE);
  localparam int unsigned HALF = PRESCALE / 2;

  logic ss_press, lr_press;

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_ss_debounce (
    .qzt_clk (qzt_clk),
    .reset   (reset),
    .btn     (btn_start_stop),
    .press   (ss_press)
  );

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_lr_debounce (
    .qzt_clk (qzt_clk),
    .reset   (reset),
    .btn     (btn_lap_reset),
    .press   (lr_press)
  );

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          count_clk_q, count_clk_d;
  logic          counter_clr_q, counter_clr_d;
  logic          freeze_q, freeze_d;
  logic          running_q, running_d;

  // Outputs are derived from the next state so each registered output lines up
  // with the state it belongs to (e.g. prescaler already zero in CLEAR).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (ss_press) state_d = ST_RUNNING;
      ST_RUNNING: if (ss_press) state_d = ST_STOPPED;
                  else if (lr_press) state_d = ST_LAP;
      ST_LAP:     if (ss_press) state_d = ST_STOPPED;
                  else if (lr_press) state_d = ST_RUNNING;
      ST_STOPPED: if (ss_press) state_d = ST_RUNNING;
                  else if (lr_press) state_d = ST_CLEAR;
      ST_CLEAR:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_RUNNING, ST_LAP: presc_d = (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + 1'b1;
      ST_STOPPED:         presc_d = presc_q;
      default:            presc_d = '0;
    endcase

    count_clk_d   = (presc_d >= PW'(HALF));
    counter_clr_d = (state_d == ST_CLEAR);
    freeze_d      = (state_d == ST_LAP);
    running_d     = (state_d == ST_RUNNING) || (state_d == ST_LAP);
  end

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      presc_q       <= '0;
      count_clk_q   <= 1'b0;
      counter_clr_q <= 1'b0;
      freeze_q      <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      count_clk_q   <= count_clk_d;
      counter_clr_q <= counter_clr_d;
      freeze_q      <= freeze_d;
      running_q     <= running_d;
    end
  end

  assign state       = state_q;
  assign count_clk   = count_clk_q;
  assign counter_clr = counter_clr_q;
  assign freeze      = freeze_q;
  assign running     = running_q;

endmodule

// File: tb/tb_chrono_controller.sv
// Bench for chrono_controller: directed scenarios then random button activity,
// every cycle compared against a window-based reference model of the stopwatch.
module tb_chrono_controller;

  localparam int unsigned P = 4;
  localparam int unsigned D = 3;

  logic       qzt_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       btn_ss  = 1'b0;
  logic       btn_lr  = 1'b0;
  logic       count_clk, counter_clr, freeze, running;
  logic [2:0] state;

  chrono_controller #(.PRESCALE(P), .DEBOUNCE(D)) dut (
    .qzt_clk        (qzt_clk),
    .reset          (reset),
    .btn_start_stop (btn_ss),
    .btn_lap_reset  (btn_lr),
    .count_clk      (count_clk),
    .counter_clr    (counter_clr),
    .freeze         (freeze),
    .running        (running),
    .state          (state)
  );

  always #5 qzt_clk = ~qzt_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: state number, prescaler count, per-button accepted level,
  // pulse visible this cycle, pending rise, and a ring of raw button samples.
  int m_state = 0;
  int m_cnt   = 0;
  int n_edge  = 0;
  bit m_acc[2];
  bit m_pulse[2];
  bit m_rise[2];
  bit hist[2][16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit s0, input bit s1);
    int  nxt;
    bit  diff;
    if (rst) begin
      m_state = 0;
      m_cnt   = 0;
      n_edge  = 0;
      for (int b = 0; b < 2; b++) begin
        m_acc[b]   = 1'b1;
        m_pulse[b] = 1'b0;
        m_rise[b]  = 1'b0;
      end
    end else begin
      nxt = m_state;
      case (m_state)
        0: if (m_pulse[0]) nxt = 1;
        1: if (m_pulse[0]) nxt = 3; else if (m_pulse[1]) nxt = 2;
        2: if (m_pulse[0]) nxt = 3; else if (m_pulse[1]) nxt = 1;
        3: if (m_pulse[0]) nxt = 1; else if (m_pulse[1]) nxt = 4;
        default: nxt = 0;
      endcase
      if (nxt == 1 || nxt == 2) m_cnt = (m_cnt + 1) % P;
      else if (nxt != 3)        m_cnt = 0;
      m_state = nxt;

      hist[0][n_edge % 16] = s0;
      hist[1][n_edge % 16] = s1;
      // A level is accepted once the last D synchronized samples (raw samples
      // delayed two edges) all differ from the currently accepted level.
      for (int b = 0; b < 2; b++) begin
        m_pulse[b] = m_rise[b];
        m_rise[b]  = 1'b0;
        if (n_edge >= int'(D) + 1) begin
          diff = 1'b1;
          for (int k = 0; k < int'(D); k++)
            if (hist[b][(n_edge - k - 2) % 16] == m_acc[b]) diff = 1'b0;
          if (diff) begin
            m_acc[b]  = ~m_acc[b];
            m_rise[b] = m_acc[b];
          end
        end
      end
      n_edge++;
    end
  endtask

  task automatic tick();
    @(posedge qzt_clk);
    model_edge(reset, btn_ss, btn_lr);
    @(negedge qzt_clk);
    chk("state",       state,       m_state);
    chk("count_clk",   count_clk,   32'(m_cnt >= int'(P / 2)));
    chk("counter_clr", counter_clr, 32'(m_state == 4));
    chk("freeze",      freeze,      32'(m_state == 2));
    chk("running",     running,     32'(m_state == 1 || m_state == 2));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input bit ss, input bit lr);
    btn_ss = ss;
    btn_lr = lr;
    cycles(6);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    cycles(8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n_clear;
    int h0;
    int h1;

    reset = 1'b1;
    cycles(3);
    chk("rst_state", state, 0);
    chk("rst_count_clk", count_clk, 0);
    chk("rst_running", running, 0);
    reset = 1'b0;
    cycles(8);

    // Held start/stop: one pulse, state changes on the edge after it.
    btn_ss = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (state == 3'd1 && lat == 0) lat = i;
    end
    chk("ss_latency", lat, D + 4);
    chk("held_single_pulse", state, 1);
    btn_ss = 1'b0;
    cycles(8);

    press(1'b0, 1'b1);
    chk("lap_state", state, 2);
    chk("lap_freeze", freeze, 1);
    press(1'b0, 1'b1);
    chk("unlap_state", state, 1);
    chk("unlap_freeze", freeze, 0);

    // Align so the stop lands with count_clk high.
    for (int i = 0; i < 8 && m_cnt != 0; i++) tick();
    press(1'b1, 1'b0);
    chk("stop_state", state, 3);
    chk("stop_clk_high", count_clk, 1);
    cycles(20);
    chk("stop_clk_hold", count_clk, 1);
    press(1'b1, 1'b0);
    chk("resume_state", state, 1);

    press(1'b1, 1'b0);
    chk("stop2_state", state, 3);
    btn_lr = 1'b1;
    n_clear = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 6) btn_lr = 1'b0;
      tick();
      if (state == 3'd4) n_clear++;
    end
    chk("clear_len", n_clear, 1);
    chk("clear_to_idle", state, 0);
    chk("idle_clk_low", count_clk, 0);

    press(1'b1, 1'b0);
    chk("run_again", state, 1);
    press(1'b1, 1'b1);
    chk("simul_ss_wins", state, 3);
    btn_ss = 1'b1;
    cycles(2);
    btn_ss = 1'b0;
    cycles(12);
    chk("glitch_ignored", state, 3);

    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("lap_before_rst", state, 2);
    btn_lr = 1'b1;
    cycles(3);
    reset = 1'b1;
    cycles(2);
    chk("rst_lap_state", state, 0);
    chk("rst_lap_freeze", freeze, 0);
    chk("rst_lap_clr", counter_clr, 0);
    reset = 1'b0;
    cycles(20);
    chk("lr_held_idle", state, 0);
    btn_ss = 1'b1;
    cycles(6);
    btn_ss = 1'b0;
    cycles(10);
    chk("lr_held_no_pulse", state, 1);
    btn_lr = 1'b0;
    cycles(8);
    press(1'b0, 1'b1);
    chk("lr_repress", state, 2);

    press(1'b0, 1'b1);
    btn_ss = 1'b1;
    cycles(2);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(20);
    chk("ss_held_no_pulse", state, 0);
    btn_ss = 1'b0;
    cycles(8);
    press(1'b1, 1'b0);
    chk("ss_repress", state, 1);

    h0 = 0;
    h1 = 0;
    for (int i = 0; i < 1500; i++) begin
      if (h0 == 0) begin btn_ss = ~btn_ss; h0 = int'($urandom_range(1, 9)); end
      else h0--;
      if (h1 == 0) begin btn_lr = ~btn_lr; h1 = int'($urandom_range(1, 12)); end
      else h1--;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset  = 1'b0;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    cycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
